// File: rtl/inst_fetch_queue_if.sv
// ROM read port and decode handshake of the instruction fetch queue.
// master = fetch queue, slave = ROM/decode side.
interface inst_fetch_queue_if #(
  parameter int AW = 10,
  parameter int IW = 9
) ();
  logic [AW-1:0] RomAddr;
  logic [IW-1:0] RomData;
  logic          InstValid;
  logic [IW-1:0] Inst;
  logic [AW-1:0] InstPC;
  logic          InstReady;

  modport master (
    output RomAddr,
    input  RomData,
    output InstValid,
    output Inst,
    output InstPC,
    input  InstReady
  );

  modport slave (
    input  RomAddr,
    output RomData,
    input  InstValid,
    input  Inst,
    input  InstPC,
    output InstReady
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers ROM words in a small FIFO and
// presents the oldest one to decode. Define FETCH_STATS_EN to build the statistics counters.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int IW    = 9
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Halt,
  input  logic               Redirect,
  input  logic [AW-1:0]      RedirectTarget,
  inst_fetch_queue_if.master fetch_if,
  output logic               Running,
  output logic [15:0]        StatFetched,
  output logic [15:0]        StatFlushed,
  output logic [15:0]        StatStall
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = IW + AW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e        state_q;
  logic          running_q;
  logic [AW-1:0] fetch_pc_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [EW-1:0] mem_q [DEPTH];

  logic          in_run_s;
  logic          valid_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          flush_s;
  logic          restart_s;
  logic [EW-1:0] head_s;

  assign valid_s = (count_q != {CW{1'b0}});
  assign full_s  = (count_q == CW'(DEPTH));

  // Halt beats Redirect; a full FIFO still accepts a push when the head is popped.
  always_comb begin
    in_run_s  = (state_q == S_RUN);
    restart_s = in_run_s & Start;
    pop_s     = valid_s & fetch_if.InstReady & in_run_s & ~Halt;
    flush_s   = in_run_s & ~Start & ~Halt & Redirect;
    push_s    = in_run_s & ~Start & ~Halt & ~Redirect & (~full_s | pop_s);
    head_s    = mem_q[rd_ptr_q];
  end

  assign fetch_if.RomAddr   = fetch_pc_q;
  assign fetch_if.InstValid = valid_s;
  assign fetch_if.Inst      = valid_s ? head_s[EW-1:AW] : {IW{1'b1}};
  assign fetch_if.InstPC    = valid_s ? head_s[AW-1:0] : {AW{1'b0}};
  assign Running            = running_q;

  // FIFO storage: each entry is {instruction, pc}, written at the tail.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {fetch_if.RomData, fetch_pc_q};
    end
  end

  // Control FSM, fetch PC and FIFO pointers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      running_q  <= 1'b0;
      fetch_pc_q <= {AW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q <= S_PRIME;
          end
        end
        S_PRIME: begin
          fetch_pc_q <= {AW{1'b0}};
          rd_ptr_q   <= {PW{1'b0}};
          wr_ptr_q   <= {PW{1'b0}};
          count_q    <= {CW{1'b0}};
          if (!Start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (restart_s) begin
            state_q    <= S_PRIME;
            running_q  <= 1'b0;
            fetch_pc_q <= {AW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
          end else if (Halt) begin
            state_q   <= S_HALTED;
            running_q <= 1'b0;
          end else if (flush_s) begin
            fetch_pc_q <= RedirectTarget;
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
          end else begin
            if (push_s) begin
              wr_ptr_q   <= wr_ptr_q + PW'(1'b1);
              fetch_pc_q <= fetch_pc_q + AW'(1'b1);
            end
            if (pop_s) begin
              rd_ptr_q <= rd_ptr_q + PW'(1'b1);
            end
            if (push_s && !pop_s) begin
              count_q <= count_q + CW'(1'b1);
            end else if (pop_s && !push_s) begin
              count_q <= count_q - CW'(1'b1);
            end
          end
        end
        S_HALTED: begin
          if (Start) begin
            state_q    <= S_PRIME;
            fetch_pc_q <= {AW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched_q;
  logic [15:0] stat_flushed_q;
  logic [15:0] stat_stall_q;
  logic        enter_prime_s;
  logic        stall_s;
  logic [15:0] flush_amt_s;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // The head popped in a redirect cycle was consumed, so it is not counted as flushed.
  always_comb begin
    enter_prime_s = Start & (state_q != S_PRIME);
    stall_s       = in_run_s & ~valid_s & ~Halt;
    flush_amt_s   = 16'(count_q) - 16'(pop_s);
  end

  // Saturating statistics, cleared on every entry to PRIME.
  always_ff @(posedge Clk) begin
    if (Reset || enter_prime_s) begin
      stat_fetched_q <= 16'h0000;
      stat_flushed_q <= 16'h0000;
      stat_stall_q   <= 16'h0000;
    end else begin
      if (push_s) begin
        stat_fetched_q <= sat_add(stat_fetched_q, 16'h0001);
      end
      if (flush_s) begin
        stat_flushed_q <= sat_add(stat_flushed_q, flush_amt_s);
      end
      if (stall_s) begin
        stat_stall_q <= sat_add(stat_stall_q, 16'h0001);
      end
    end
  end

  assign StatFetched = stat_fetched_q;
  assign StatFlushed = stat_flushed_q;
  assign StatStall   = stat_stall_q;
`else
  assign StatFetched = 16'h0000;
  assign StatFlushed = 16'h0000;
  assign StatStall   = 16'h0000;
`endif

endmodule
